// File: rtl/sha3_pkg.sv
// Definitions shared by the SHA3 padder/absorber path and the digest transmitter.
package sha3_pkg;

  localparam int LANE_W   = 64;
  localparam int TX_LANES = 8;
  localparam int KEEP_W   = LANE_W / 8;

  // 224-bit digests end half-way through lane 3, so only its low four bytes are valid.
  localparam logic [KEEP_W-1:0] KEEP_224_LAST = 8'h0F;

  typedef logic [0:4][0:4][LANE_W-1:0] state_t;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } sha3_mode_e;

  function automatic logic [3:0] digest_beats(input sha3_mode_e m);
    case (m)
      MODE_384: return 4'd6;
      MODE_512: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/sha3_digest_tx_if.sv
// AXI4-Stream digest channel between the SHA3 transmitter and its consumer.
interface sha3_digest_tx_if;
  import sha3_pkg::*;

  logic [LANE_W-1:0] M_TDATA;
  logic [KEEP_W-1:0] M_TKEEP;
  logic [1:0]        M_TUSER;
  logic              M_TLAST;
  logic              M_TVALID;
  logic              M_TREADY;

  modport master (
    output M_TDATA, M_TKEEP, M_TUSER, M_TLAST, M_TVALID,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA, M_TKEEP, M_TUSER, M_TLAST, M_TVALID,
    output M_TREADY
  );

endinterface

// File: rtl/sha3_digest_tx.sv
// Captures the final Keccak state, truncates it to the selected digest and
// streams it out as 64-bit AXI4-Stream beats with TLAST/TKEEP framing.
module sha3_digest_tx
  import sha3_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  state_t            state_in,
  input  logic [1:0]        mode,
  input  logic              state_valid,
  output logic              state_ready,
  sha3_digest_tx_if.master  m_axis
);

  typedef enum logic {ST_IDLE, ST_SEND} tx_state_e;

  tx_state_e                        r_state, w_state_nxt;
  logic [TX_LANES-1:0][LANE_W-1:0]  r_buf;
  sha3_mode_e                       r_mode, w_mode_sel;
  logic [2:0]                       r_cnt, w_cnt_nxt;
  logic                             w_capture;
  logic [3:0]                       w_n_sel;

  logic              r_ready, r_tvalid, r_tlast;
  logic [LANE_W-1:0] r_tdata, w_data_nxt;
  logic [KEEP_W-1:0] r_tkeep, w_keep_nxt;
  logic [1:0]        r_tuser;
  logic              w_last_nxt;
  logic              w_unused_state;

  // Only lanes 0..7 ever leave the block; the rest of the state is dropped.
  assign w_unused_state = ^state_in;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (state_valid && r_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = 3'd0;
        end
      end
      ST_SEND: begin
        if (r_tvalid && m_axis.M_TREADY) begin
          if ({1'b0, r_cnt} == digest_beats(r_mode) - 4'd1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Next beat is precomputed so every output can leave straight from a flop.
    w_mode_sel = w_capture ? sha3_mode_e'(mode) : r_mode;
    w_n_sel    = digest_beats(w_mode_sel);
    w_data_nxt = w_capture ? state_in[0][0] : r_buf[w_cnt_nxt];
    w_last_nxt = (w_state_nxt == ST_SEND) && ({1'b0, w_cnt_nxt} == w_n_sel - 4'd1);
    w_keep_nxt = (w_mode_sel == MODE_224 && w_cnt_nxt == 3'd3) ? KEEP_224_LAST : 8'hFF;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_buf  <= '0;
      r_mode <= MODE_224;
    end else if (w_capture) begin
      r_mode   <= sha3_mode_e'(mode);
      r_buf[0] <= state_in[0][0];
      r_buf[1] <= state_in[1][0];
      r_buf[2] <= state_in[2][0];
      r_buf[3] <= state_in[3][0];
      r_buf[4] <= state_in[4][0];
      r_buf[5] <= state_in[0][1];
      r_buf[6] <= state_in[1][1];
      r_buf[7] <= state_in[2][1];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ready  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= 2'd0;
    end else begin
      r_ready  <= (w_state_nxt == ST_IDLE);
      r_tvalid <= (w_state_nxt == ST_SEND);
      r_tlast  <= w_last_nxt;
      r_tdata  <= w_data_nxt;
      r_tkeep  <= w_keep_nxt;
      r_tuser  <= w_mode_sel;
    end
  end

  assign state_ready     = r_ready;
  assign m_axis.M_TVALID = r_tvalid;
  assign m_axis.M_TLAST  = r_tlast;
  assign m_axis.M_TDATA  = r_tdata;
  assign m_axis.M_TKEEP  = r_tkeep;
  assign m_axis.M_TUSER  = r_tuser;

endmodule
